i2c_data_tx: RTL
================

I2C_DATA_TX -- requirements
Module: i2c_data_tx

Interface
REQ-001 SHALL have parameter CNT_W, default 8: width of the bytes_sent counter.
REQ-002 SHALL have parameter DOUT_IDLE, default 1'b1: DOut level when not shifting.
REQ-003 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port StartTX, input, 1: address phase acknowledged; begin data phase.
REQ-006 SHALL have port SlaveAck, input, 1: slave acknowledge, 1 = ACK, 0 = NACK.
REQ-007 SHALL have ports tx_data (input, 8), tx_valid (input, 1), tx_last (input, 1) and tx_ready (output, 1): byte source handshake; tx_last marks the final byte.
REQ-008 SHALL have port DOut, output, 1: serial data bit, MSB first.
REQ-009 SHALL have port validdata, output, 1: high while DOut carries a data bit.
REQ-010 SHALL have port ack_sample, output, 1: high in the cycle SlaveAck is sampled.
REQ-011 SHALL have ports stop (output, 1) and done (output, 1): one-cycle stop-request and phase-complete pulses.
REQ-012 SHALL have port nack_err, output, 1: sticky NACK error flag.
REQ-013 SHALL have port bytes_sent, output, CNT_W: count of ACKed bytes in the current phase.

Function
REQ-014 SHALL implement states IDLE, LOAD, SHIFT, ACK, STOP, DONE; all outputs registered.
REQ-015 IDLE: SHALL move to LOAD when StartTX=1; on that edge it SHALL clear bytes_sent and nack_err.
REQ-016 LOAD: SHALL drive tx_ready=1; on tx_valid&tx_ready it SHALL capture tx_data and tx_last, load bit index 7 and go to SHIFT. With tx_valid=0 it SHALL wait indefinitely.
REQ-017 SHIFT: SHALL hold validdata=1 for exactly 8 cycles, with DOut = byte[7] through byte[0], one bit per cycle, then go to ACK.
REQ-018 Latency: with handshake at edge k, bit 7 SHALL appear after edge k+1 and ack_sample after edge k+9. A back-to-back byte SHALL take 10 cycles when tx_valid is already high.
REQ-019 ACK: SHALL drive ack_sample=1, validdata=0 and DOut=DOUT_IDLE, and sample SlaveAck.
 - ACK, not last: SHALL increment bytes_sent (saturating at all-ones) and go to LOAD.
 - ACK, last: SHALL increment bytes_sent and go to STOP.
 - NACK: SHALL set nack_err and go to STOP, subject to REQ-026.
REQ-020 STOP: SHALL pulse stop for one cycle, then go to DONE. DONE: SHALL pulse done for one cycle, then go to IDLE.
REQ-021 StartTX SHALL be ignored outside IDLE. tx_ready SHALL be 0 outside LOAD, so tx_valid is ignored there.
REQ-022 If StartTX and tx_valid are both high in IDLE, the byte SHALL NOT be accepted until the LOAD cycle.
REQ-023 tx_data changes while in SHIFT SHALL NOT affect DOut, because the byte is held in the shift register.

Reset
REQ-024 While rst_n=0, the block SHALL enter IDLE immediately, including mid-byte, with outputs as follows:
 - DOut=DOUT_IDLE.
 - tx_ready, validdata, ack_sample, stop, done and nack_err all 0.
 - bytes_sent=0.
REQ-025 After rst_n rises, the block SHALL require a fresh StartTX. No partial byte SHALL resume.

Configuration
REQ-026 Macro I2C_DATA_NACK_RETRY_EN:
 - Defined: the first NACK on a byte SHALL reload the same captured byte and return to SHIFT without setting nack_err. A second NACK on that byte SHALL set nack_err and go to STOP. The retry counter SHALL clear on each ACK.
 - Undefined: the first NACK SHALL set nack_err and go to STOP. No retry logic SHALL be present.

Verification
REQ-027 Single byte: StartTX, then tx_data=8'hA5 with tx_last=1 and SlaveAck=1. Required: DOut=1,0,1,0,0,1,0,1; one stop pulse; one done pulse; bytes_sent=1; nack_err=0.
REQ-028 Two bytes: 8'h3C then 8'hFF (last), tx_valid held high and ACKed. Required: second byte's validdata starts 10 cycles after the first; bytes_sent=2.
REQ-029 NACK: byte 8'h81 with SlaveAck=0 at ack_sample.
 - Without the macro: nack_err=1, stop pulse, bytes_sent=0.
 - With the macro: 8'h81 is reshifted once; a second NACK then gives nack_err=1.
REQ-030 Reset mid-byte: rst_n=0 after the 4th bit. Required: immediately DOut=1 and validdata=0, state IDLE; a new StartTX restarts cleanly with bytes_sent=0.
REQ-031 Stall and ignore: tx_valid low for 5 cycles in LOAD keeps tx_ready=1 and DOut idle. StartTX pulsed during SHIFT has no effect. tx_data changed during SHIFT leaves the serial output unchanged.

Source files
------------

// File: rtl/i2c_data_tx.sv
// ---------------------------------------------------------------------------
// i2c_data_tx -- data phase of an I2C master write.
//
// After the address phase has been acknowledged (StartTX), this block pulls
// bytes from a valid/ready source. It shifts each byte out MSB first on DOut,
// one bit per clock, then samples the slave acknowledge. A NACK, or the ACK
// of the byte marked tx_last, ends the phase with a one-cycle stop request
// followed by a one-cycle done pulse.
//
// Ports
//   clk         : clock, all state changes on its rising edge
//   rst_n       : asynchronous active-low reset
//   StartTX     : address phase acknowledged, begin the data phase (IDLE only)
//   SlaveAck    : slave acknowledge, 1 = ACK, 0 = NACK
//   tx_data     : byte to send
//   tx_valid    : tx_data/tx_last are valid
//   tx_last     : this byte is the final one of the phase
//   tx_ready    : block can accept a byte (high only while loading)
//   DOut        : serial data bit, MSB first, DOUT_IDLE when not shifting
//   validdata   : DOut carries a data bit
//   ack_sample  : SlaveAck is sampled at the end of this cycle
//   stop        : one-cycle stop-condition request
//   done        : one-cycle data-phase-complete pulse
//   nack_err    : sticky NACK flag, cleared by the next StartTX
//   bytes_sent  : number of ACKed bytes in the current phase (saturating)
//
// Optional feature: define I2C_DATA_NACK_RETRY_EN to resend a byte once after
// its first NACK before flagging nack_err.
// ---------------------------------------------------------------------------
module i2c_data_tx #(
    parameter int   CNT_W     = 8,
    parameter logic DOUT_IDLE = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             StartTX,
    input  logic             SlaveAck,
    input  logic [7:0]       tx_data,
    input  logic             tx_valid,
    input  logic             tx_last,
    output logic             tx_ready,
    output logic             DOut,
    output logic             validdata,
    output logic             ack_sample,
    output logic             stop,
    output logic             done,
    output logic             nack_err,
    output logic [CNT_W-1:0] bytes_sent
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT,
        ACK,
        STOP,
        DONE
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state_q;
    logic [7:0]       byte_q;      // captured byte, held for the whole shift (and a retry)
    logic [2:0]       bit_idx_q;   // index of the bit currently on DOut
    logic             last_q;
    logic             tx_ready_q;
    logic             dout_q;
    logic             validdata_q;
    logic             ack_sample_q;
    logic             stop_q;
    logic             done_q;
    logic             nack_err_q;
    logic [CNT_W-1:0] bytes_sent_q;
`ifdef I2C_DATA_NACK_RETRY_EN
    logic             retry_q;     // current byte has already been NACKed once
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            byte_q       <= 8'h00;
            bit_idx_q    <= 3'd0;
            last_q       <= 1'b0;
            tx_ready_q   <= 1'b0;
            dout_q       <= DOUT_IDLE;
            validdata_q  <= 1'b0;
            ack_sample_q <= 1'b0;
            stop_q       <= 1'b0;
            done_q       <= 1'b0;
            nack_err_q   <= 1'b0;
            bytes_sent_q <= '0;
`ifdef I2C_DATA_NACK_RETRY_EN
            retry_q      <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (StartTX) begin
                        state_q      <= LOAD;
                        tx_ready_q   <= 1'b1;
                        bytes_sent_q <= '0;
                        nack_err_q   <= 1'b0;
                    end
                end

                LOAD: begin
                    // tx_ready_q is always high here, so tx_valid alone completes
                    // the handshake; the MSB goes straight onto DOut.
                    if (tx_valid) begin
                        state_q     <= SHIFT;
                        tx_ready_q  <= 1'b0;
                        byte_q      <= tx_data;
                        last_q      <= tx_last;
                        bit_idx_q   <= 3'd7;
                        dout_q      <= tx_data[7];
                        validdata_q <= 1'b1;
`ifdef I2C_DATA_NACK_RETRY_EN
                        retry_q     <= 1'b0;
`endif
                    end
                end

                SHIFT: begin
                    if (bit_idx_q != 3'd0) begin
                        bit_idx_q <= bit_idx_q - 3'd1;
                        dout_q    <= byte_q[bit_idx_q - 3'd1];
                    end else begin
                        // bit 0 has had its cycle; release the line for the ACK slot
                        state_q      <= ACK;
                        dout_q       <= DOUT_IDLE;
                        validdata_q  <= 1'b0;
                        ack_sample_q <= 1'b1;
                    end
                end

                ACK: begin
                    ack_sample_q <= 1'b0;
                    if (SlaveAck) begin
                        if (bytes_sent_q != '1) begin
                            bytes_sent_q <= bytes_sent_q + CNT_ONE;
                        end
`ifdef I2C_DATA_NACK_RETRY_EN
                        retry_q <= 1'b0;
`endif
                        if (last_q) begin
                            state_q <= STOP;
                            stop_q  <= 1'b1;
                        end else begin
                            state_q    <= LOAD;
                            tx_ready_q <= 1'b1;
                        end
                    end else begin
`ifdef I2C_DATA_NACK_RETRY_EN
                        if (!retry_q) begin
                            // resend the held byte once, starting with its MSB
                            retry_q     <= 1'b1;
                            state_q     <= SHIFT;
                            bit_idx_q   <= 3'd7;
                            dout_q      <= byte_q[7];
                            validdata_q <= 1'b1;
                        end else begin
                            nack_err_q <= 1'b1;
                            state_q    <= STOP;
                            stop_q     <= 1'b1;
                        end
`else
                        nack_err_q <= 1'b1;
                        state_q    <= STOP;
                        stop_q     <= 1'b1;
`endif
                    end
                end

                STOP: begin
                    stop_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= DONE;
                end

                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign tx_ready   = tx_ready_q;
    assign DOut       = dout_q;
    assign validdata  = validdata_q;
    assign ack_sample = ack_sample_q;
    assign stop       = stop_q;
    assign done       = done_q;
    assign nack_err   = nack_err_q;
    assign bytes_sent = bytes_sent_q;

endmodule
